// File: rtl/aes_block_loader.sv
// Sequential operand loader and ciphertext streamer for a 128-bit combinational AES core.
// Operands and ciphertext use the core's [0:127] ordering: word 0 is bits 0..31, the MSBs.
module aes_block_loader #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_word,
  input  logic         key_reuse,
  output logic [0:127] core_key,
  output logic [0:127] core_data,
  input  logic [0:127] core_ct,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_word,
  output logic         out_last,
  output logic         busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_KEY, S_DATA, S_WAIT, S_OUT} state_t;

  state_t           state;
  logic [1:0]       beat_cnt;
  logic [1:0]       out_idx;
  logic [CNT_W-1:0] settle_cnt;
  logic             key_loaded;
  logic [0:127]     ct_reg;

  logic             accept;
  logic [6:0]       beat_base;
  logic [1:0]       next_idx;
  logic [6:0]       next_out_base;

  // Beat transfer and word offsets; in_ready is only high in the load states
  assign accept        = in_valid && in_ready;
  assign beat_base     = {beat_cnt, 5'd0};
  assign next_idx      = out_idx + 2'd1;
  assign next_out_base = {next_idx, 5'd0};

  // Loader state machine with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_KEY;
      beat_cnt   <= 2'd0;
      out_idx    <= 2'd0;
      settle_cnt <= '0;
      key_loaded <= 1'b0;
      ct_reg     <= '0;
      core_key   <= '0;
      core_data  <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_word   <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_KEY: begin
          if (accept) begin
            if (beat_cnt == 2'd0 && key_reuse && key_loaded) begin
              core_data[0:31] <= in_word;
              beat_cnt        <= 2'd1;
              state           <= S_DATA;
            end else begin
              core_key[beat_base +: 32] <= in_word;
              beat_cnt                  <= beat_cnt + 2'd1;
              if (beat_cnt == 2'd3) begin
                key_loaded <= 1'b1;
                state      <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            core_data[beat_base +: 32] <= in_word;
            beat_cnt                   <= beat_cnt + 2'd1;
            if (beat_cnt == 2'd3) begin
              state      <= S_WAIT;
              settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
              in_ready   <= 1'b0;
              busy       <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          settle_cnt <= settle_cnt - CNT_W'(1);
          if (settle_cnt == '0) begin
            ct_reg    <= core_ct;
            out_idx   <= 2'd0;
            out_word  <= core_ct[0:31];
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            if (out_idx == 2'd3) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              beat_cnt  <= 2'd0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              state     <= S_KEY;
            end else begin
              out_idx  <= next_idx;
              out_word <= ct_reg[next_out_base +: 32];
              out_last <= (next_idx == 2'd3);
            end
          end
        end
        default: state <= S_KEY;
      endcase
    end
  end

endmodule
